// File: rtl/zed_pkg.sv
// Shared types and constants for the source-Z phrase generator.
// Z values are 16.16 fixed point; a phrase carries four integer Z lanes.
package zed_pkg;

    localparam int ZINT  = 16;
    localparam int ZFRAC = 16;
    localparam int ZPIX  = 4;

    // Bit offsets of the two 16-bit lanes inside a 32-bit phrase half
    localparam int LANE_LO = 0;
    localparam int LANE_HI = ZINT;

    typedef enum logic [1:0] {
        ZG_IDLE  = 2'd0,
        ZG_SETUP = 2'd1,
        ZG_EMIT  = 2'd2
    } zg_state_t;

    // Valid-pixel mask for a partial phrase holding r (1..3) pixels
    function automatic logic [ZPIX-1:0] partial_mask(input logic [1:0] r);
        logic [ZPIX-1:0] m;
        case (r)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/zedgen_if.sv
// Phrase handshake between the Z generator (master) and the Z comparator (slave).
interface zedgen_if;
    logic [31:0] srczplo;
    logic [31:0] srczphi;
    logic [3:0]  pix_mask;
    logic        srcz_valid;
    logic        srcz_ready;

    modport master (
        output srczplo, srczphi, pix_mask, srcz_valid,
        input  srcz_ready
    );

    modport slave (
        input  srczplo, srczphi, pix_mask, srcz_valid,
        output srcz_ready
    );
endinterface

// File: rtl/zedgen_lanes.sv
// Four-lane Z interpolation: acc + {0, zinc, 2*zinc, 3*zinc}, truncated to integers
// and packed into the low/high phrase halves.
module zedgen_lanes
    import zed_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [31:0] zinc,
    input  logic [31:0] inc2,
    input  logic [31:0] inc3,
    output logic [31:0] lo_nxt,
    output logic [31:0] hi_nxt
);

    // Sums wrap modulo 2^32; the shift drops the fraction without rounding
    always_comb begin
        lo_nxt = '0;
        hi_nxt = '0;
        lo_nxt[LANE_LO +: ZINT] = ZINT'(acc >> ZFRAC);
        lo_nxt[LANE_HI +: ZINT] = ZINT'((acc + zinc) >> ZFRAC);
        hi_nxt[LANE_LO +: ZINT] = ZINT'((acc + inc2) >> ZFRAC);
        hi_nxt[LANE_HI +: ZINT] = ZINT'((acc + inc3) >> ZFRAC);
    end

endmodule

// File: rtl/zedgen.sv
// Source-Z phrase generator: steps a 16.16 Z accumulator across a span and
// emits four interpolated integer Z values per accepted phrase.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ZG_IDLE  | waiting for start; span parameters latched on start
// ZG_SETUP | one cycle: build step multiples, present first phrase
// ZG_EMIT  | phrase valid; advance acc/rem on each accept until span ends
module zedgen
    import zed_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            resetl,
    input  logic            start,
    input  logic            abort,
    input  logic [31:0]     zinit,
    input  logic [31:0]     zinc,
    input  logic [CNTW-1:0] npix,
    zedgen_if.master        phr,
    output logic            busy,
    output logic            done
);

    zg_state_t       state;
    logic [31:0]     acc_r;
    logic [31:0]     zinc_r;
    logic [31:0]     inc2_r;
    logic [31:0]     inc3_r;
    logic [31:0]     inc4_r;
    logic [CNTW-1:0] rem_r;

    logic [31:0]     srczplo_r;
    logic [31:0]     srczphi_r;
    logic [3:0]      pix_mask_r;
    logic            srcz_valid_r;

    logic [31:0]     inc2_c;
    logic [31:0]     inc3_c;
    logic [31:0]     inc4_c;
    logic [31:0]     acc_step;
    logic [CNTW-1:0] rem_step;
    logic [31:0]     lane_acc;
    logic [31:0]     lane_inc2;
    logic [31:0]     lane_inc3;
    logic [CNTW-1:0] lane_rem;
    logic [3:0]      mask_nxt;
    logic [31:0]     lo_nxt;
    logic [31:0]     hi_nxt;
    logic            accept;

    function automatic logic [3:0] mask_for(input logic [CNTW-1:0] r);
        if (r >= CNTW'(ZPIX)) return 4'b1111;
        return partial_mask(r[1:0]);
    endfunction

    // In SETUP the step multiples are not registered yet, so the first phrase
    // is built from the combinational values; afterwards from the next acc.
    always_comb begin
        inc2_c    = zinc_r << 1;
        inc3_c    = zinc_r + inc2_c;
        inc4_c    = zinc_r << 2;
        acc_step  = acc_r + inc4_r;
        rem_step  = rem_r - CNTW'(ZPIX);
        lane_acc  = (state == ZG_SETUP) ? acc_r  : acc_step;
        lane_inc2 = (state == ZG_SETUP) ? inc2_c : inc2_r;
        lane_inc3 = (state == ZG_SETUP) ? inc3_c : inc3_r;
        lane_rem  = (state == ZG_SETUP) ? rem_r  : rem_step;
        mask_nxt  = mask_for(lane_rem);
        accept    = srcz_valid_r & phr.srcz_ready;
    end

    zedgen_lanes u_lanes (
        .acc    (lane_acc),
        .zinc   (zinc_r),
        .inc2   (lane_inc2),
        .inc3   (lane_inc3),
        .lo_nxt (lo_nxt),
        .hi_nxt (hi_nxt)
    );

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state        <= ZG_IDLE;
            acc_r        <= '0;
            zinc_r       <= '0;
            inc2_r       <= '0;
            inc3_r       <= '0;
            inc4_r       <= '0;
            rem_r        <= '0;
            srczplo_r    <= '0;
            srczphi_r    <= '0;
            pix_mask_r   <= '0;
            srcz_valid_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ZG_IDLE) begin
                state        <= ZG_IDLE;
                srcz_valid_r <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ZG_IDLE: begin
                        if (start && !abort) begin
                            acc_r  <= zinit;
                            zinc_r <= zinc;
                            rem_r  <= npix;
                            busy   <= 1'b1;
                            state  <= ZG_SETUP;
                        end
                    end
                    ZG_SETUP: begin
                        inc2_r <= inc2_c;
                        inc3_r <= inc3_c;
                        inc4_r <= inc4_c;
                        if (rem_r == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ZG_IDLE;
                        end else begin
                            srczplo_r    <= lo_nxt;
                            srczphi_r    <= hi_nxt;
                            pix_mask_r   <= mask_nxt;
                            srcz_valid_r <= 1'b1;
                            state        <= ZG_EMIT;
                        end
                    end
                    ZG_EMIT: begin
                        if (accept) begin
                            if (rem_r > CNTW'(ZPIX)) begin
                                acc_r      <= acc_step;
                                rem_r      <= rem_step;
                                srczplo_r  <= lo_nxt;
                                srczphi_r  <= hi_nxt;
                                pix_mask_r <= mask_nxt;
                            end else begin
                                srcz_valid_r <= 1'b0;
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                state        <= ZG_IDLE;
                            end
                        end
                    end
                    default: state <= ZG_IDLE;
                endcase
            end
        end
    end

    assign phr.srczplo    = srczplo_r;
    assign phr.srczphi    = srczphi_r;
    assign phr.pix_mask   = pix_mask_r;
    assign phr.srcz_valid = srcz_valid_r;

endmodule

// File: tb/tb_zedgen.sv
// Self-checking bench for zedgen: table of spans plus hand-written corner sequences,
// with a phrase scoreboard checked on every accept.
module tb_zedgen;

    logic        clk;
    logic        resetl;
    logic        start;
    logic        abort;
    logic [31:0] zinit;
    logic [31:0] zinc;
    logic [15:0] npix;
    logic        busy;
    logic        done;

    zedgen_if ifc ();

    zedgen #(.CNTW(16)) dut (
        .clk    (clk),
        .resetl (resetl),
        .start  (start),
        .abort  (abort),
        .zinit  (zinit),
        .zinc   (zinc),
        .npix   (npix),
        .phr    (ifc),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  mask;
    } phr_t;

    typedef struct {
        logic [31:0] zi;
        logic [31:0] zc;
        logic [15:0] np;
        logic [31:0] lo0;
        logic [31:0] hi0;
        logic [3:0]  m0;
        int          nphr;
    } vec_t;

    phr_t        sb_q[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    bit          valid_seen = 0;
    logic [31:0] first_lo, first_hi;
    logic [3:0]  first_mask, last_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: lane k = acc + k*zinc, integer part of each lane
    task automatic push_span(input logic [31:0] zi, input logic [31:0] zc, input logic [15:0] np);
        logic [31:0] a;
        logic [31:0] z0, z1, z2, z3;
        int r;
        phr_t p;
        a = zi;
        r = int'(np);
        while (r > 0) begin
            z0 = a;
            z1 = a + zc;
            z2 = a + zc * 2;
            z3 = a + zc * 3;
            p.lo   = {z1[31:16], z0[31:16]};
            p.hi   = {z3[31:16], z2[31:16]};
            p.mask = (r >= 4) ? 4'hF : 4'((1 << r) - 1);
            sb_q.push_back(p);
            a = a + zc * 4;
            r = r - 4;
        end
    endtask

    always @(negedge clk) begin
        if (resetl && ifc.srcz_valid) valid_seen = 1'b1;
        if (resetl && ifc.srcz_valid && ifc.srcz_ready && !abort) begin
            acc_cnt++;
            if (acc_cnt == 1) begin
                first_lo   = ifc.srczplo;
                first_hi   = ifc.srczphi;
                first_mask = ifc.pix_mask;
            end
            last_mask = ifc.pix_mask;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_phrase: got lo=%h hi=%h, expected none", ifc.srczplo, ifc.srczphi);
            end else begin
                phr_t e;
                e = sb_q.pop_front();
                chk("sb_lo", ifc.srczplo, e.lo);
                chk("sb_hi", ifc.srczphi, e.hi);
                chk("sb_mask", 32'(ifc.pix_mask), 32'(e.mask));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; busy one cycle later, valid two cycles later
    task automatic start_span(input logic [31:0] zi, input logic [31:0] zc,
                              input logic [15:0] np, input bit exp_valid);
        zinit = zi;
        zinc  = zc;
        npix  = np;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_after_start", 32'(ifc.srcz_valid), 32'd0);
        step();
        chk("valid_2cyc", 32'(ifc.srcz_valid), 32'(exp_valid));
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        logic [31:0] h_lo, h_hi;
        logic [3:0]  h_mask;

        vecs[0] = '{32'h0010_0000, 32'h0001_0000, 16'd8, 32'h0011_0010, 32'h0013_0012, 4'hF, 2};
        vecs[1] = '{32'h0000_8000, 32'h0000_8000, 16'd4, 32'h0001_0000, 32'h0002_0001, 4'hF, 1};
        vecs[2] = '{32'h0001_0000, 32'hFFFF_0000, 16'd4, 32'h0000_0001, 32'hFFFE_FFFF, 4'hF, 1};
        vecs[3] = '{32'h1234_5678, 32'h0002_3456, 16'd3, 32'h1236_1234, 32'h123A_1238, 4'h7, 1};
        vecs[4] = '{32'hFFFF_0000, 32'h0001_0000, 16'd1, 32'h0000_FFFF, 32'h0002_0001, 4'h1, 1};
        vecs[5] = '{32'h0000_0000, 32'h0000_4000, 16'd5, 32'h0000_0000, 32'h0000_0000, 4'hF, 2};

        resetl = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        zinit  = '0;
        zinc   = '0;
        npix   = '0;
        ifc.srcz_ready = 1'b0;
        #23;
        chk("rst_valid", 32'(ifc.srcz_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lo", ifc.srczplo, 32'd0);
        chk("rst_hi", ifc.srczphi, 32'd0);
        chk("rst_mask", 32'(ifc.pix_mask), 32'd0);
        resetl = 1'b1;
        step();

        // Table of spans with ready held high
        ifc.srcz_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            acc_cnt = 0;
            push_span(vecs[i].zi, vecs[i].zc, vecs[i].np);
            start_span(vecs[i].zi, vecs[i].zc, vecs[i].np, 1'b1);
            wait_done(40, n);
            chk("done_latency", 32'(n), 32'(vecs[i].nphr));
            chk("accepts", 32'(acc_cnt), 32'(vecs[i].nphr));
            chk("first_lo", first_lo, vecs[i].lo0);
            chk("first_hi", first_hi, vecs[i].hi0);
            chk("first_mask", 32'(first_mask), 32'(vecs[i].m0));
            chk("valid_after_done", 32'(ifc.srcz_valid), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
            step();
            chk("done_pulse_1cyc", 32'(done), 32'd0);
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
        end

        // Partial final phrase with a 3-cycle stall; a start during the span is ignored
        ifc.srcz_ready = 1'b0;
        acc_cnt = 0;
        push_span(32'h0010_0000, 32'h0001_0000, 16'd6);
        start_span(32'h0010_0000, 32'h0001_0000, 16'd6, 1'b1);
        h_lo = ifc.srczplo;
        h_hi = ifc.srczphi;
        h_mask = ifc.pix_mask;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                start = 1'b1;
                zinit = 32'hDEAD_0000;
                npix  = 16'd3;
            end
            step();
            start = 1'b0;
            chk("stall_valid", 32'(ifc.srcz_valid), 32'd1);
            chk("stall_lo", ifc.srczplo, h_lo);
            chk("stall_hi", ifc.srczphi, h_hi);
            chk("stall_mask", 32'(ifc.pix_mask), 32'(h_mask));
        end
        ifc.srcz_ready = 1'b1;
        wait_done(40, n);
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        chk("bp_last_mask", 32'(last_mask), 32'h3);
        step();
        chk("bp_no_restart", 32'(busy), 32'd0);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Zero-length span
        valid_seen = 1'b0;
        start_span(32'h0010_0000, 32'h0001_0000, 16'd0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        chk("zero_done_clear", 32'(done), 32'd0);
        chk("zero_no_valid", 32'(valid_seen), 32'd0);

        // Abort together with an accept mid-span
        acc_cnt = 0;
        push_span(32'h0020_0000, 32'h0001_0000, 16'd12);
        start_span(32'h0020_0000, 32'h0001_0000, 16'd12, 1'b1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(ifc.srcz_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        step();
        chk("abort_done_later", 32'(done), 32'd0);
        chk("abort_accepts", 32'(acc_cnt), 32'd1);
        sb_q.delete();

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        npix  = 16'd4;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        step();
        chk("sa_valid", 32'(ifc.srcz_valid), 32'd0);

        // New start in the same cycle as done
        acc_cnt = 0;
        push_span(32'h0030_0000, 32'h0001_0000, 16'd4);
        start_span(32'h0030_0000, 32'h0001_0000, 16'd4, 1'b1);
        wait_done(40, n);
        acc_cnt = 0;
        push_span(32'h0040_0000, 32'h0002_0000, 16'd4);
        start_span(32'h0040_0000, 32'h0002_0000, 16'd4, 1'b1);
        wait_done(40, n);
        chk("b2b_lo", first_lo, 32'h0042_0040);
        chk("b2b_hi", first_hi, 32'h0046_0044);

        // Asynchronous reset during EMIT, then restart
        ifc.srcz_ready = 1'b0;
        push_span(32'h0010_0000, 32'h0001_0000, 16'd16);
        start_span(32'h0010_0000, 32'h0001_0000, 16'd16, 1'b1);
        #2;
        resetl = 1'b0;
        #1;
        chk("arst_valid", 32'(ifc.srcz_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lo", ifc.srczplo, 32'd0);
        chk("arst_hi", ifc.srczphi, 32'd0);
        chk("arst_mask", 32'(ifc.pix_mask), 32'd0);
        sb_q.delete();
        step();
        resetl = 1'b1;
        valid_seen = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("post_rst_no_valid", 32'(valid_seen), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        ifc.srcz_ready = 1'b1;
        acc_cnt = 0;
        push_span(32'h0050_0000, 32'h0001_0000, 16'd4);
        start_span(32'h0050_0000, 32'h0001_0000, 16'd4, 1'b1);
        wait_done(40, n);
        chk("restart_lo", first_lo, 32'h0051_0050);
        chk("restart_hi", first_hi, 32'h0053_0052);
        chk("restart_accepts", 32'(acc_cnt), 32'd1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
